// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch (F) and data (D) requesters
// D has priority; F is forced after MAX_D_STREAK D grants it waited through; a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_valid,
  output logic        f_stall,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic                WD_EN      = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STREAK_W-1:0] streak;
  logic [WD_W-1:0]     wd_cnt;

  logic grant_d;
  logic grant_f;
  logic busy;
  logic ack_hit;
  logic wd_hit;
  logic finish;

  assign f_stall = f_req & ~f_valid;
  assign d_stall = d_req & ~d_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    state_nxt = state;
    busy      = (state == BUSY_F) || (state == BUSY_D);
    ack_hit   = busy && mem_ack;
    // an ack arriving on the expiry cycle wins over the timeout
    wd_hit    = busy && WD_EN && !mem_ack && (wd_cnt == WD_LAST);
    finish    = ack_hit || wd_hit;
    case (state)
      IDLE: begin
        if (d_req && !(f_req && (streak == STREAK_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (f_req) begin
          grant_f   = 1'b1;
          state_nxt = BUSY_F;
        end
      end
      BUSY_F, BUSY_D: begin
        if (finish) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      f_valid   <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      streak    <= '0;
      wd_cnt    <= '0;
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_rw    <= d_rw;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_size  <= d_size;
        wd_cnt    <= '0;
        // streak only counts D grants that fetch had to wait through
        if (!f_req) begin
          streak <= '0;
        end else if (streak != STREAK_MAX) begin
          streak <= streak + 1'b1;
        end
      end else if (grant_f) begin
        mem_req   <= 1'b1;
        mem_rw    <= 1'b0;
        mem_addr  <= f_addr;
        mem_wdata <= '0;
        mem_size  <= 2'd2;
        wd_cnt    <= '0;
        streak    <= '0;
      end

      if (busy) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (finish) begin
          mem_req <= 1'b0;
          f_valid <= (state == BUSY_F);
          d_valid <= (state == BUSY_D);
          if (ack_hit && (state == BUSY_F)) begin
            f_rdata <= mem_rdata;
          end
          if (ack_hit && (state == BUSY_D) && !mem_rw) begin
            d_rdata <= mem_rdata;
          end
          if (wd_hit) begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
